// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit subtractor computing a - b - bin, LSB first,
//               one bit per clock through a single full-subtractor cell with
//               a registered borrow. start/done handshake, borrow chaining,
//               unsigned borrow-out and signed overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // A counter of at least one bit keeps WIDTH=1 legal.
    localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_ovf_nxt;

    // Full-subtractor cell on the current LSBs plus the result shift-in.
    // The new bit enters at the MSB so after WIDTH shifts the LSB-first
    // stream sits in its natural position; written as a shift/or so the
    // same expression holds for WIDTH=1.
    always_comb begin
        w_x       = r_a_sr[0];
        w_y       = r_b_sr[0];
        w_d       = w_x ^ w_y ^ r_br;
        w_br_nxt  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        w_res_nxt = (r_res_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
        // On the last bit w_d is the result MSB.
        w_ovf_nxt = (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_nxt;
                    r_br     <= w_br_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        // Publish the whole word at once; diff never shows
                        // a partially shifted result.
                        r_diff  <= w_res_nxt;
                        r_bout  <= w_br_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8 and
//               WIDTH=1 instances) with a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    logic       s1_start;
    logic       s1_a;
    logic       s1_b;
    logic       s1_bin;
    logic       s1_busy;
    logic       s1_done;
    logic       s1_diff;
    logic       s1_bout;
    logic       s1_ovf;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [9:0] q8[$];      // {ovf, bout, diff}
    logic [2:0] q1[$];      // {ovf, bout, diff}
    logic [7:0] prev_diff;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bout(s1_bout), .ovf(s1_ovf)
    );

    // Reference: unsigned 9-bit difference for diff/bout, signed range test for ovf.
    function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        logic [8:0] u;
        int         s;
        u = {1'b0, ma} - {1'b0, mb} - {8'b0, mbin};
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        return {(s < -128 || s > 127), u[8], u[7:0]};
    endfunction

    function automatic logic [2:0] model1(input logic x, input logic y, input logic z);
        logic [1:0] u;
        int         s;
        u = {1'b0, x} - {1'b0, y} - {1'b0, z};
        s = -int'(x) + int'(y) - int'(z);   // 1-bit signed: 1 means -1
        return {(s < -1 || s > 0), u[1], u[0]};
    endfunction

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; s1_start = 1'b1;
        a = 8'hAA; b = 8'h11; bin = 1'b1; s1_a = 1'b1; s1_b = 1'b0; s1_bin = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (diff !== 8'h00) $display("FAIL reset_diff: got %h expected 00", diff); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL reset_bout: got %b expected 0", bout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (s1_busy !== 1'b0) $display("FAIL reset_w1_busy: got %b expected 0", s1_busy); else n_pass++;
        rst = 1'b0; start = 1'b0; s1_start = 1'b0;
        @(negedge clk);
        prev_diff = 8'h00;
    endtask

    // Directed vectors with constant expected results.
    task automatic test_table();
        logic [7:0] ta[6];
        logic [7:0] tbv[6];
        logic [7:0] td[6];
        logic       tbin[6];
        logic       tbo[6];
        logic       tov[6];
        logic [9:0] exp;
        logic       hold_ok;
        logic       got;
        int         cyc;
        ta   = '{8'd100, 8'h00, 8'h80, 8'h7F, 8'h05, 8'h10};
        tbv  = '{8'd37,  8'h01, 8'h01, 8'hFF, 8'h05, 8'h0F};
        tbin = '{1'b0,   1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        td   = '{8'h3F,  8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00};
        tbo  = '{1'b0,   1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        tov  = '{1'b0,   1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 6; i++) begin
            q8.push_back({tov[i], tbo[i], td[i]});
            issue8(ta[i], tbv[i], tbin[i]);
            hold_ok = 1'b1; got = 1'b0; cyc = 0;
            for (int c = 1; c <= 40 && !got; c++) begin
                if (busy !== 1'b1 || diff !== prev_diff) hold_ok = 1'b0;
                @(negedge clk); cyc = c; got = done;
            end
            exp = q8.pop_front();
            n_checks++; if (hold_ok !== 1'b1) $display("FAIL busy_hold[%0d]: got 0 expected busy=1 and diff held at %h", i, prev_diff); else n_pass++;
            n_checks++; if (cyc !== 8 || got !== 1'b1) $display("FAIL latency[%0d]: got %0d cycles (done=%b) expected 8", i, cyc, got); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL busy_at_done[%0d]: got %b expected 0", i, busy); else n_pass++;
            n_checks++; if (diff !== exp[7:0]) $display("FAIL diff[%0d]: got %h expected %h", i, diff, exp[7:0]); else n_pass++;
            n_checks++; if (bout !== exp[8]) $display("FAIL bout[%0d]: got %b expected %b", i, bout, exp[8]); else n_pass++;
            n_checks++; if (ovf !== exp[9]) $display("FAIL ovf[%0d]: got %b expected %b", i, ovf, exp[9]); else n_pass++;
            prev_diff = exp[7:0];
            @(negedge clk);
            n_checks++; if (done !== 1'b0) $display("FAIL done_pulse[%0d]: got %b expected 0", i, done); else n_pass++;
        end
    endtask

    // start held high, fresh random operands every cycle.
    task automatic test_back_to_back();
        logic [9:0] exp;
        logic [9:0] last_push;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        int         ndone;
        logic       spacing_ok;
        logic       overlap_ok;
        ndone = 0; spacing_ok = 1'b1; overlap_ok = 1'b1; last_push = '0;
        for (int n = 0; n <= 27; n++) begin
            if (n > 0) begin
                if (done && busy) overlap_ok = 1'b0;
                if (done) begin
                    if (n % 9 != 0) spacing_ok = 1'b0;
                    ndone++;
                    exp = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
                    n_checks++; if ({ovf, bout, diff} !== exp) $display("FAIL b2b_result[%0d]: got %h expected %h", ndone, {ovf, bout, diff}, exp); else n_pass++;
                end
            end
            if (n < 27) begin
                ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
                a = ra; b = rb; bin = rbin; start = 1'b1;
                if (n % 9 == 0) begin
                    last_push = model8(ra, rb, rbin);
                    q8.push_back(last_push);
                end
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (ndone !== 3) $display("FAIL b2b_count: got %0d results expected 3", ndone); else n_pass++;
        n_checks++; if (spacing_ok !== 1'b1) $display("FAIL b2b_spacing: got off-grid done expected every 9 cycles"); else n_pass++;
        n_checks++; if (overlap_ok !== 1'b1) $display("FAIL b2b_done_busy: got done with busy=1 expected never"); else n_pass++;
        q8.delete();
        prev_diff = last_push[7:0];
    endtask

    // Inputs scrambled and a stray start while busy; result and idling unaffected.
    task automatic test_mid_op();
        logic [9:0] exp;
        logic       got;
        logic       quiet;
        int         cyc;
        q8.push_back(model8(8'h55, 8'h22, 1'b0));
        issue8(8'h55, 8'h22, 1'b0);
        got = 1'b0; cyc = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = (c == 3);
            @(negedge clk); cyc = c; got = done;
        end
        start = 1'b0;
        exp = q8.pop_front();
        n_checks++; if (cyc !== 8 || got !== 1'b1) $display("FAIL midop_latency: got %0d cycles (done=%b) expected 8", cyc, got); else n_pass++;
        n_checks++; if ({ovf, bout, diff} !== exp) $display("FAIL midop_result: got %h expected %h", {ovf, bout, diff}, exp); else n_pass++;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) $display("FAIL midop_not_queued: got extra activity expected idle"); else n_pass++;
        prev_diff = exp[7:0];
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        logic       got;
        logic       quiet;
        int         cyc;
        issue8(8'hC3, 8'h11, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (diff !== 8'h00) $display("FAIL rstmid_diff: got %h expected 00", diff); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL rstmid_bout: got %b expected 0", bout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rstmid_ovf: got %b expected 0", ovf); else n_pass++;
        rst = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) $display("FAIL rstmid_aborted: got done/busy after reset expected none"); else n_pass++;
        q8.push_back(model8(8'hC3, 8'h11, 1'b0));
        issue8(8'hC3, 8'h11, 1'b0);
        got = 1'b0; cyc = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk); cyc = c; got = done;
        end
        exp = q8.pop_front();
        n_checks++; if (cyc !== 8 || got !== 1'b1) $display("FAIL rstmid_after_latency: got %0d cycles (done=%b) expected 8", cyc, got); else n_pass++;
        n_checks++; if ({ovf, bout, diff} !== exp) $display("FAIL rstmid_after_result: got %h expected %h", {ovf, bout, diff}, exp); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic [2:0] exp;
        logic [2:0] v;
        logic       got;
        int         cyc;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            q1.push_back(model1(v[2], v[1], v[0]));
            s1_a = v[2]; s1_b = v[1]; s1_bin = v[0]; s1_start = 1'b1;
            @(negedge clk);
            s1_start = 1'b0;
            got = 1'b0; cyc = 0;
            for (int c = 1; c <= 20 && !got; c++) begin
                @(negedge clk); cyc = c; got = s1_done;
            end
            exp = q1.pop_front();
            n_checks++; if (cyc !== 1 || got !== 1'b1) $display("FAIL w1_latency[%0d]: got %0d cycles (done=%b) expected 1", i, cyc, got); else n_pass++;
            n_checks++; if ({s1_bout, s1_diff} !== exp[1:0]) $display("FAIL w1_result[a,b,bin=%b]: got bout,diff=%b expected %b", v, {s1_bout, s1_diff}, exp[1:0]); else n_pass++;
            n_checks++; if (s1_ovf !== exp[2]) $display("FAIL w1_ovf[a,b,bin=%b]: got %b expected %b", v, s1_ovf, exp[2]); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_table();
        test_back_to_back();
        test_mid_op();
        test_reset_mid();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, parametrised N-bit subtractor computing a − b − bin, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the multi-bit, sequential successor to the team's combinational full subtractor. Width-scalable arithmetic fits in minimal logic, at the cost of WIDTH cycles of latency. A start/done handshake lets a controller issue operations and chain borrows across words.

## Interface

- WIDTH, 8, operand/result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result updates.
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH.
- bout  output  1  final borrow out (unsigned a < b + bin).
- ovf  output  1  signed (two's-complement) overflow of the subtraction.

## Operation

- **States:**
  - IDLE → SHIFT on `start`.
  - SHIFT → IDLE after the WIDTH-th bit, with `done` asserted.
- **Accept (IDLE and `start`=1):**
  - Load the operand shift registers with a and b.
  - Load the borrow register with bin.
  - Clear the bit counter.
  - Save a[WIDTH-1] and b[WIDTH-1] for the overflow calculation.
- **Per SHIFT cycle:**
  - With x = a_sr[0], y = b_sr[0], br = borrow register:
    - d = x ^ y ^ br
    - br' = (~x & y) | (~(x ^ y) & br)
  - Shift d into the MSB of the result shift register.
  - Shift both operand registers right by 1.
  - Increment the counter.
- **Last bit (counter = WIDTH-1):**
  - diff ← completed result register.
  - bout ← br' from the last bit.
  - ovf ← (a_msb ^ b_msb) & (diff_msb ^ a_msb).
  - done ← 1, busy ← 0, go to IDLE.
- **Output holding:** diff, bout and ovf hold their last result until the next completion. Partial results are never visible on diff.
- **start while busy:** ignored, not queued. Operands captured at accept are unaffected by later input changes.
- **WIDTH = 1:** behaves exactly as the full subtractor. diff = a^b^bin; bout = (~a&b) | (~(a^b)&bin).

## Timing

- **Reset:** rst=1 at an edge forces state IDLE, counter 0, busy=0, done=0, diff=0, bout=0, ovf=0. rst overrides start.
- **Reset mid-operation:** the operation is aborted, no done pulse is produced, and outputs return to 0.
- **Accept:** edge E0. busy=1 from after E0 until edge E_WIDTH.
- **Bit processing:** bit i is processed at edge E(i+1), for i = 0..WIDTH-1.
- **Completion at edge E_WIDTH:**
  - diff, bout and ovf update.
  - done=1 for exactly one cycle.
  - busy=0.
- **Latency:** WIDTH cycles from accepting edge to done.
- **Back-to-back:** start high during the done cycle is accepted at the next edge. Sustained throughput is one result per WIDTH+1 cycles.
- **done:** never high in two consecutive cycles, and never high while busy=1.

## Test plan

- **Basic, WIDTH=8:** a=100, b=37, bin=0, start pulse.
  - Required: busy high for 8 cycles, then done pulses 8 cycles after accept.
  - Result: diff=63 (0x3F), bout=0, ovf=0.
- **Wrap and overflow, WIDTH=8:**
  - 0x00−0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
  - 0x80−0x01 → diff=0x7F, bout=0, ovf=1.
  - 0x7F−0xFF → diff=0x80, bout=1, ovf=1.
- **Borrow-in chaining, WIDTH=8:**
  - 0x05−0x05, bin=1 → diff=0xFF, bout=1.
  - 0x10−0x0F, bin=1 → diff=0x00, bout=0.
- **Handshake, WIDTH=8:**
  - start held high continuously with new a/b each cycle: results equal operands sampled only at accepting edges, and done spacing is exactly 9 cycles.
  - Mid-op input changes do not alter the result.
- **Reset, WIDTH=8:** assert rst at bit 4 of an operation.
  - Required: next cycle busy=0, done=0, diff=0, bout=0, ovf=0.
  - A subsequent operation completes normally.
- **WIDTH=1 exhaustive:** all 8 (a, b, bin) combinations.
  - diff and bout match the full-subtractor truth table, e.g. (0,1,1) → diff=0, bout=1; (1,0,0) → diff=1, bout=0.
  - done arrives 1 cycle after accept.
